aclock_display: RTL and testbench

Six-digit multiplexed seven-segment driver that reads the BCD time outputs of `Aclock` (HH:MM:SS) and drives a common-anode display. It is the reader end of the clock's time-output interface. It snapshots all six digits once per scan frame so a frame is never torn, decodes BCD to segments, blanks a leading hour zero, and optionally blinks the whole display while `Alarm` is asserted. It sits between `Aclock` and the board pins.

---
 rtl/aclock_display.sv | 116 +++++++++++
 tb/tb_aclock_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/aclock_display.sv
// aclock_display: six-digit multiplexed common-anode seven-segment driver for Aclock HH.MM.SS.
// Defining ACLK_DISPLAY_BLINK_EN adds whole-display blinking while Alarm is asserted.
module aclock_display #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic [3:0] S_in1,
    input  logic [3:0] S_in0,
    input  logic       Alarm,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_tick
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [5:0][3:0] snap_q, snap_d;
    logic            run_q, ft_q;
    logic [6:0]      seg_q, seg_d;
    logic [5:0]      an_q, an_d;
    logic            dp_q, dp_d;
    logic            phase_q;
    logic            wrap, capture, blank;
    logic [3:0]      digit;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    dec7 = 7'h40;
            4'd1:    dec7 = 7'h79;
            4'd2:    dec7 = 7'h24;
            4'd3:    dec7 = 7'h30;
            4'd4:    dec7 = 7'h19;
            4'd5:    dec7 = 7'h12;
            4'd6:    dec7 = 7'h02;
            4'd7:    dec7 = 7'h78;
            4'd8:    dec7 = 7'h00;
            4'd9:    dec7 = 7'h10;
            default: dec7 = 7'h3F;
        endcase
    endfunction

    // run_q holds the display dark for the first cycle so digit 0 first shows the fresh snapshot
    always_comb begin
        wrap    = pcnt_q == PW'(SCAN_DIV - 1);
        capture = idx_q == 3'd0 && pcnt_q == '0;
        pcnt_d  = wrap ? '0 : pcnt_q + 1'b1;
        idx_d   = !wrap ? idx_q : (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        snap_d  = capture ? {{2'b00, H_in1}, H_in0, M_in1, M_in0, S_in1, S_in0} : snap_q;
        digit   = snap_q[idx_q];
        blank   = !run_q || !phase_q;
        seg_d   = (blank || (idx_q == 3'd5 && digit == 4'd0)) ? 7'h7F : dec7(digit);
        an_d    = blank ? 6'h3F : ~(6'd1 << idx_q);
        dp_d    = blank || !(idx_q == 3'd2 || idx_q == 3'd4);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            run_q  <= 1'b0;
            ft_q   <= 1'b0;
            seg_q  <= 7'h7F;
            an_q   <= 6'h3F;
            dp_q   <= 1'b1;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            run_q  <= 1'b1;
            ft_q   <= capture;
            seg_q  <= seg_d;
            an_q   <= an_d;
            dp_q   <= dp_d;
        end
    end

`ifdef ACLK_DISPLAY_BLINK_EN
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_d, last;

    always_comb begin
        last    = bcnt_q == BW'(BLINK_FRAMES - 1);
        bcnt_d  = !Alarm ? '0 : !capture ? bcnt_q : last ? '0 : bcnt_q + 1'b1;
        phase_d = !Alarm ? 1'b1 : (capture && last) ? !phase_q : phase_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    logic unused_alarm;
    assign unused_alarm = Alarm;
    assign phase_q      = 1'b1;
`endif

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = ft_q;
endmodule

// File: tb/tb_aclock_display.sv
// tb_aclock_display: randomized self-checking bench for aclock_display against a frame/phase arithmetic model.
module tb_aclock_display;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int F  = 6 * SD;
`ifdef ACLK_DISPLAY_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] H_in1 = '0;
    logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0, S_in1 = '0, S_in0 = '0;
    logic       Alarm = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_tick;

    aclock_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1),
        .M_in0(M_in0), .S_in1(S_in1), .S_in0(S_in0), .Alarm(Alarm),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model: n = edges since reset release, c_m = frames captured while Alarm stayed high
    int         n = 0;
    int         c_m = 0;
    logic [3:0] snap_m [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [6:0] dec_t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [14:0] exp_o;

    task automatic step();
        int d;
        logic [3:0] v;
        logic [6:0] es;
        logic [5:0] ea;
        logic ed;
        bit cap;
        @(posedge clk);
        n++;
        cap = ((n - 1) % F) == 0;
        d = ((n - 1) / SD) % 6;
        v = snap_m[d];
        ea = 6'h3F ^ (6'd1 << d);
        es = (d == 5 && v == 4'd0) ? 7'h7F : (v > 4'd9) ? 7'h3F : dec_t[v];
        ed = !(d == 2 || d == 4);
        if (n == 1 || (BLINK && (c_m / BF) % 2 == 1)) begin
            ea = 6'h3F;
            es = 7'h7F;
            ed = 1'b1;
        end
        exp_o = {ea, es, ed, cap};
        if (cap) snap_m = '{S_in0, S_in1, M_in0, M_in1, H_in0, {2'b00, H_in1}};
        c_m = !Alarm ? 0 : cap ? c_m + 1 : c_m;
        #1;
    endtask

    task automatic do_release();
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        c_m = 0;
        snap_m = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    endtask

    task automatic set_time(input logic [1:0] h1, input logic [3:0] h0, m1, m0, s1, s0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0; S_in1 = s1; S_in0 = s0;
    endtask

    task automatic test_reset();
        set_time(2'd1, 4'd0, 4'd1, 4'd9, 4'd5, 4'd9);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({an, seg, dp, frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0})
            $display("FAIL reset_hold got=%h want=%h", {an, seg, dp, frame_tick}, {6'h3F, 7'h7F, 1'b1, 1'b0});
        else passed++;
        do_release();
        step();
        checks++;
        if ({an, seg, dp, frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b1})
            $display("FAIL first_edge got=%h want=%h", {an, seg, dp, frame_tick}, {6'h3F, 7'h7F, 1'b1, 1'b1});
        else passed++;
        step();
        checks++;
        if ({an, seg, dp, frame_tick} !== {6'h3E, 7'h10, 1'b1, 1'b0})
            $display("FAIL first_digit got=%h want=%h", {an, seg, dp, frame_tick}, {6'h3E, 7'h10, 1'b1, 1'b0});
        else passed++;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 2 * F; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_o)
                $display("FAIL scan n=%0d got=%h want=%h", n, {an, seg, dp, frame_tick}, exp_o);
            else passed++;
        end
    endtask

    task automatic test_leading_zero();
        set_time(2'd0, 4'd7, 4'd1, 4'hC, 4'd5, 4'd9);
        for (int i = 0; i < 2 * F; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_o)
                $display("FAIL lead_zero n=%0d got=%h want=%h", n, {an, seg, dp, frame_tick}, exp_o);
            else passed++;
        end
    endtask

    task automatic test_snapshot();
        set_time(2'd1, 4'd0, 4'd1, 4'd9, 4'd5, 4'd9);
        for (int i = 0; i < 2 * F && !(i > F && (n / SD) % 6 == 3); i++) step();
        S_in0 = 4'd0;
        for (int i = 0; i < 2 * F; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_o)
                $display("FAIL snapshot n=%0d got=%h want=%h", n, {an, seg, dp, frame_tick}, exp_o);
            else passed++;
        end
    endtask

    task automatic test_blink();
        bit found = 1'b0;
        Alarm = 1'b1;
        for (int i = 0; i < 10 * F; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_o)
                $display("FAIL blink n=%0d got=%h want=%h", n, {an, seg, dp, frame_tick}, exp_o);
            else passed++;
            if (!BLINK) begin
                checks++;
                if ($countones(~an) !== 1) $display("FAIL no_blank n=%0d an=%h want one low", n, an);
                else passed++;
            end
        end
        if (BLINK) begin
            for (int i = 0; i < 4 * F * BF && !found; i++) begin
                step();
                found = an == 6'h3F && (n % SD) == 1;
            end
            checks++;
            if (!found) $display("FAIL blink_off_seen an=%h want 3f within bound", an);
            else passed++;
            Alarm = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                checks++;
                if ({an, seg, dp, frame_tick} !== exp_o)
                    $display("FAIL alarm_drop n=%0d got=%h want=%h", n, {an, seg, dp, frame_tick}, exp_o);
                else passed++;
            end
            checks++;
            if ($countones(~an) !== 1) $display("FAIL alarm_drop_an an=%h want one low", an);
            else passed++;
        end
        Alarm = 1'b0;
    endtask

    task automatic test_reset_mid();
        repeat (7) step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp, frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0})
            $display("FAIL reset_mid got=%h want=%h", {an, seg, dp, frame_tick}, {6'h3F, 7'h7F, 1'b1, 1'b0});
        else passed++;
        repeat (2) @(posedge clk);
        set_time(2'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd8);
        do_release();
        for (int i = 0; i < F + 2; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_o)
                $display("FAIL restart n=%0d got=%h want=%h", n, {an, seg, dp, frame_tick}, exp_o);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30 * F; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_time(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 59) == 0) Alarm = !Alarm;
            step();
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_o)
                $display("FAIL random n=%0d got=%h want=%h", n, {an, seg, dp, frame_tick}, exp_o);
            else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_leading_zero();
        test_snapshot();
        test_blink();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
